// File: rtl/led_pkg.sv
// Shared constants for the countdown display: active-low 7-segment patterns,
// FSM state encoding, BCD digit width and the load-value digit clamp.
package led_pkg;

   localparam int BCD_W = 4;

   // Segment order {g,f,e,d,c,b,a}, active low
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_PAUSE,
      ST_DONE
   } state_e;

   function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
      return (d > 4'd9) ? 4'd9 : d;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with forced blank.
module seg7_decode
   import led_pkg::*;
(
   input  logic [BCD_W-1:0] bcd_i,
   input  logic             blank_i,
   output logic [6:0]       seg_o
);

   always_comb begin
      seg_o = SEG_BLANK;
      if (!blank_i) begin
         case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
         endcase
      end
   end

endmodule

// File: rtl/led_countdown_scan.sv
// Multi-digit BCD countdown timer with start/pause/clear and a multiplexed
// common-anode display. Define LED_LZB_EN to blank leading zeros.
module led_countdown_scan
   import led_pkg::*;
#(
   parameter int DIGITS      = 8,
   parameter int TICK_CYCLES = 100000000,
   parameter int SCAN_CYCLES = 200000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    btn_start,
   input  logic                    btn_pause,
   input  logic                    btn_clear,
   input  logic [BCD_W*DIGITS-1:0] load_val,
   output logic [DIGITS-1:0]       led_en,
   output logic [6:0]              led_seg,
   output logic                    led_dp,
   output logic                    done
);

   localparam int CNT_W  = BCD_W * DIGITS;
   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int SCAN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic              start_q, pause_q, clear_q;
   logic              start_e, pause_e, clear_e;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d, count_dec, load_clamped;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic              tick_wrap;
   logic              done_q;
   logic [SCAN_W-1:0] scan_q;
   logic [IDX_W-1:0]  idx_q;
   logic [DIGITS-1:0] led_en_q, en_d;
   logic [6:0]        led_seg_q, seg_d;
   logic [BCD_W-1:0]  cur_bcd;
   logic              cur_blank;

   assign start_e   = btn_start & ~start_q;
   assign pause_e   = btn_pause & ~pause_q;
   assign clear_e   = btn_clear & ~clear_q;
   assign tick_wrap = (tick_q == TICK_W'(TICK_CYCLES - 1));

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      load_clamped = '0;
      for (int i = 0; i < DIGITS; i++)
         load_clamped[i*BCD_W +: BCD_W] = clamp_bcd(load_val[i*BCD_W +: BCD_W]);
   end

   // Decrement with borrow rippling from digit 0 upwards
   always_comb begin
      logic borrow;
      count_dec = count_q;
      borrow    = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (count_q[i*BCD_W +: BCD_W] == '0) begin
               count_dec[i*BCD_W +: BCD_W] = 4'd9;
            end else begin
               count_dec[i*BCD_W +: BCD_W] = count_q[i*BCD_W +: BCD_W] - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      tick_d  = tick_q;
      if (clear_e) begin
         count_d = load_clamped;
         tick_d  = '0;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_e) begin
                  state_d = (count_q == '0) ? ST_DONE : ST_RUN;
                  tick_d  = '0;
               end
            end
            ST_RUN: begin
               // A coincident start edge outranks pause, so keep running
               if (pause_e && !start_e) begin
                  state_d = ST_PAUSE;
               end else if (tick_wrap) begin
                  tick_d  = '0;
                  count_d = count_dec;
                  if (count_dec == '0) state_d = ST_DONE;
               end else begin
                  tick_d = tick_q + TICK_W'(1);
               end
            end
            ST_PAUSE: begin
               if (start_e) state_d = ST_RUN;
            end
            ST_DONE: begin
               count_d = '0;
               if (start_e && load_clamped != '0) begin
                  count_d = load_clamped;
                  tick_d  = '0;
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= 1'b0;
         pause_q <= 1'b0;
         clear_q <= 1'b0;
         state_q <= ST_IDLE;
         count_q <= '0;
         tick_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         start_q <= btn_start;
         pause_q <= btn_pause;
         clear_q <= btn_clear;
         state_q <= state_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         done_q  <= (state_d == ST_DONE);
      end
   end

   // Digit select, enable pattern and optional leading-zero blanking
   always_comb begin
      logic upper_nz;
      cur_bcd   = '0;
      en_d      = '1;
      upper_nz  = 1'b0;
      cur_blank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            cur_bcd = count_q[i*BCD_W +: BCD_W];
            en_d[i] = 1'b0;
         end
         if (IDX_W'(i) >= idx_q && count_q[i*BCD_W +: BCD_W] != '0) upper_nz = 1'b1;
      end
`ifdef LED_LZB_EN
      cur_blank = (idx_q != '0) && !upper_nz;
`else
      cur_blank = 1'b0;
`endif
   end

   seg7_decode u_seg7_decode (
      .bcd_i   (cur_bcd),
      .blank_i (cur_blank),
      .seg_o   (seg_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_q    <= '0;
         idx_q     <= '0;
         led_en_q  <= '1;
         led_seg_q <= SEG_BLANK;
      end else begin
         if (scan_q == SCAN_W'(SCAN_CYCLES - 1)) begin
            scan_q <= '0;
            idx_q  <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
         end else begin
            scan_q <= scan_q + SCAN_W'(1);
         end
         led_en_q  <= en_d;
         led_seg_q <= seg_d;
      end
   end

   assign led_en  = led_en_q;
   assign led_seg = led_seg_q;
   assign led_dp  = 1'b1;
   assign done    = done_q;

endmodule

// File: tb/tb_led_countdown_scan.sv
// Scoreboard bench for led_countdown_scan (DIGITS=4, TICK_CYCLES=10, SCAN_CYCLES=3).
// Expected count/done/enable/segment events are queued with the cycle they are due.
module tb_led_countdown_scan;

   localparam int DIGITS = 4;

`ifdef LED_LZB_EN
   localparam logic [6:0] EXP_LZ = 7'h7F;
`else
   localparam logic [6:0] EXP_LZ = 7'h40;
`endif

   typedef struct {
      logic [15:0] val;
      int          at;
   } ev_t;

   typedef struct {
      int         idx;
      logic [6:0] seg;
   } disp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        btn_start = 1'b0;
   logic        btn_pause = 1'b0;
   logic        btn_clear = 1'b0;
   logic [15:0] load_val = 16'h0000;
   logic [3:0]  led_en;
   logic [6:0]  led_seg;
   logic        led_dp;
   logic        done;

   int cyc = 0;
   int n_checks = 0;
   int n_fail = 0;

   ev_t   cnt_exp[$];
   ev_t   done_exp[$];
   ev_t   en_exp[$];
   disp_t disp_exp[$];

   logic [15:0] last_cnt = 16'h0000;
   logic        last_done = 1'b0;
   logic [3:0]  last_en = 4'hF;

   led_countdown_scan #(
      .DIGITS      (DIGITS),
      .TICK_CYCLES (10),
      .SCAN_CYCLES (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_start (btn_start),
      .btn_pause (btn_pause),
      .btn_clear (btn_clear),
      .load_val  (load_val),
      .led_en    (led_en),
      .led_seg   (led_seg),
      .led_dp    (led_dp),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [31:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: unexpected change to %0h, required no change (cycle %0d)", name, act, cyc);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a new value
   always @(negedge clk) begin
      ev_t   e;
      disp_t d;
      if (!rst_n) begin
         last_cnt  = dut.count_q;
         last_done = done;
         last_en   = led_en;
      end else begin
         if (dut.count_q !== last_cnt) begin
            if (cnt_exp.size() == 0) unexpected("count", dut.count_q);
            else begin
               e = cnt_exp.pop_front();
               check("count_value", dut.count_q, e.val);
               check("count_cycle", cyc, e.at);
            end
            last_cnt = dut.count_q;
         end
         if (done !== last_done) begin
            if (done_exp.size() == 0) unexpected("done", done);
            else begin
               e = done_exp.pop_front();
               check("done_value", done, e.val);
               check("done_cycle", cyc, e.at);
            end
            last_done = done;
         end
         if (led_en !== last_en) begin
            if (en_exp.size() != 0) begin
               e = en_exp.pop_front();
               check("led_en_value", led_en, e.val);
               check("led_en_cycle", cyc, e.at);
            end
            last_en = led_en;
         end
         if (disp_exp.size() != 0 && led_en == ~(4'b0001 << disp_exp[0].idx)) begin
            d = disp_exp.pop_front();
            check($sformatf("led_seg_digit%0d", d.idx), led_seg, d.seg);
            check("led_dp", led_dp, 1'b1);
         end
      end
   end

   function automatic int pending();
      return cnt_exp.size() + done_exp.size() + en_exp.size() + disp_exp.size();
   endfunction

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (pending() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_pending"}, pending(), 0);
      cnt_exp.delete();
      done_exp.delete();
      en_exp.delete();
      disp_exp.delete();
   endtask

   task automatic pulse(input bit s, input bit p, input bit c);
      btn_start = s;
      btn_pause = p;
      btn_clear = c;
      @(negedge clk);
      btn_start = 1'b0;
      btn_pause = 1'b0;
      btn_clear = 1'b0;
   endtask

   task automatic push_cnt(input logic [15:0] v, input int at);
      cnt_exp.push_back('{val: v, at: at});
   endtask

   task automatic push_done(input logic v, input int at);
      done_exp.push_back('{val: {15'd0, v}, at: at});
   endtask

   task automatic push_disp(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
      disp_exp.push_back('{idx: 0, seg: s0});
      disp_exp.push_back('{idx: 1, seg: s1});
      disp_exp.push_back('{idx: 2, seg: s2});
      disp_exp.push_back('{idx: 3, seg: s3});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, r, e;

      // Power-on reset values
      #1 rst_n = 1'b0;
      #1;
      check("reset_led_en", led_en, 4'hF);
      check("reset_led_seg", led_seg, 7'h7F);
      check("reset_done", done, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Load 0012 and count down to zero
      load_val = 16'h0012;
      @(negedge clk);
      e = cyc + 1;
      push_cnt(16'h0012, e);
      pulse(0, 0, 1);
      repeat (2) @(negedge clk);
      push_disp(7'h24, 7'h79, EXP_LZ, EXP_LZ);
      drain(40, "display_0012");
      @(negedge clk);
      s = cyc + 1;
      push_cnt(16'h0011, s + 10);
      push_cnt(16'h0010, s + 20);
      for (int k = 3; k <= 12; k++) push_cnt(16'(12 - k), s + 10 * k);
      push_done(1'b1, s + 120);
      pulse(1, 0, 0);
      drain(200, "run_0012");

      // Borrow: reload 0100 from DONE, one tick gives 0099; A5 clamps to 95
      load_val = 16'h0100;
      @(negedge clk);
      s = cyc + 1;
      push_cnt(16'h0100, s);
      push_cnt(16'h0099, s + 10);
      push_done(1'b0, s);
      pulse(1, 0, 0);
      while (cyc < s + 12) @(negedge clk);
      load_val = 16'h00A5;
      e = cyc + 1;
      push_cnt(16'h0095, e);
      pulse(0, 0, 1);
      drain(30, "borrow_clamp");

      // Pause at tick 4 for 50 cycles, resume: decrement 6 cycles later
      @(negedge clk);
      s = cyc + 1;
      pulse(1, 0, 0);
      while (cyc < s + 4) @(negedge clk);
      pulse(0, 1, 0);
      repeat (50) @(negedge clk);
      r = cyc + 1;
      push_cnt(16'h0094, r + 6);
      pulse(1, 0, 0);
      while (cyc < r + 8) @(negedge clk);
      load_val = 16'h0000;
      e = cyc + 1;
      push_cnt(16'h0000, e);
      pulse(0, 0, 1);
      drain(30, "pause_resume");

      // Clear and start together in RUN: reload and stay idle
      load_val = 16'h0005;
      @(negedge clk);
      e = cyc + 1;
      push_cnt(16'h0005, e);
      pulse(0, 0, 1);
      pulse(1, 0, 0);
      repeat (3) @(negedge clk);
      load_val = 16'h0042;
      e = cyc + 1;
      push_cnt(16'h0042, e);
      pulse(1, 0, 1);
      repeat (40) @(negedge clk);
      drain(5, "clear_start");

      // Start in IDLE with zero count goes straight to DONE; pause/start ignored there
      load_val = 16'h0000;
      @(negedge clk);
      e = cyc + 1;
      push_cnt(16'h0000, e);
      pulse(0, 0, 1);
      s = cyc + 1;
      push_done(1'b1, s);
      pulse(1, 0, 0);
      repeat (5) @(negedge clk);
      pulse(0, 1, 0);
      repeat (15) @(negedge clk);
      pulse(1, 0, 0);
      repeat (20) @(negedge clk);
      drain(5, "idle_zero_done");

      // Display of 0007 with and without leading-zero blanking
      load_val = 16'h0007;
      @(negedge clk);
      e = cyc + 1;
      push_cnt(16'h0007, e);
      push_done(1'b0, e);
      pulse(0, 0, 1);
      repeat (2) @(negedge clk);
      push_disp(7'h78, EXP_LZ, EXP_LZ, EXP_LZ);
      drain(40, "display_0007");

      // Asynchronous reset mid-RUN, then the scan restarts from digit 0
      pulse(1, 0, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_reset_led_en", led_en, 4'hF);
      check("midrun_reset_led_seg", led_seg, 7'h7F);
      check("midrun_reset_done", done, 1'b0);
      check("midrun_reset_count", dut.count_q, 16'h0000);
      repeat (2) @(negedge clk);
      r = cyc + 1;
      en_exp.push_back('{val: 16'hE, at: r});
      en_exp.push_back('{val: 16'hD, at: r + 3});
      en_exp.push_back('{val: 16'hB, at: r + 6});
      en_exp.push_back('{val: 16'h7, at: r + 9});
      en_exp.push_back('{val: 16'hE, at: r + 12});
      rst_n = 1'b1;
      drain(30, "scan_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
